hazard_mc: RTL
==============

# hazard_mc

Parametrised hazard unit for the five-stage pipelined CPU. It adds a multi-cycle execution unit (multiply/divide class) to the existing forwarding, load-use and branch-flush logic. The unit tracks that unit's in-flight destination in a per-register scoreboard and a latency counter. It emits the pipeline stall, flush and forward controls consumed by the fetch, decode and execute stage registers.

## Interface
Parameters:
- ADDR_W, 6, register address width; NREG = 2**ADDR_W scoreboard entries
- MC_LAT, 4, multi-cycle unit latency in cycles (legal range 2..15)
- ZERO_REG, 0, when 1 address 0 never matches, forwards, stalls or is scoreboarded

Ports (all synchronous to clk):
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- RA1D, RA2D, WA3D  in  ADDR_W  decode source/destination addresses
- RegWriteD, McOpD  in  1  decode instruction writes a register / is multi-cycle
- RA1E, RA2E, WA3E  in  ADDR_W  execute source/destination addresses
- MemToRegE, McStartE, BranchTakenE  in  1  execute is a load / multi-cycle issue / taken branch
- WA3M, WA3W  in  ADDR_W  memory/writeback destinations
- RegWriteM, RegWriteW  in  1  memory/writeback write enables
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  PC-writing instruction in each stage
- StallF, StallD, FlushD, FlushE  out  1  pipeline controls
- FowardAE, FowardBE  out  2  execute operand select: 00 regfile, 01 W result, 10 M result
- match  out  4  {RA2E==WA3W, RA2E==WA3M, RA1E==WA3W, RA1E==WA3M}, each gated by its RegWrite
- McWriteW  out  1  multi-cycle result writes the register file this cycle
- McWA  out  ADDR_W  destination of that write
- McBusy  out  1  counter non-zero

## Operation
- Registered state: sb[NREG], cnt[3:0], McWA. Everything else is combinational.
- Forwarding: priority is M over W. FowardAE = 10 if match[0]; else 01 if match[1]; else 00. FowardBE is the same using match[2] and match[3].
- LDRStall = MemToRegE & (RA1D==WA3E | RA2D==WA3E).
- Issue: McStartE & cnt<=1. Effect: cnt <= MC_LAT, McWA <= WA3E, sb[WA3E] <= 1.
  - McStartE while cnt>1 is a protocol violation. The issue is ignored and state is unchanged.
- Count: cnt decrements each cycle while non-zero.
  - McWriteW = (cnt==1). At the end of that cycle sb[McWA] clears, unless the same edge issues to the same address, in which case the bit stays set.
- RAW hazard on a D source RA: (sb[RA] & !bypass) | (McStartE & WA3E==RA).
  - bypass = McWriteW & McWA==RA & !(McStartE & WA3E==RA). The register file writes in the first half-cycle, so decode reads the result in that same cycle.
- WAW hazard: RegWriteD & sb[WA3D] & !(McWriteW & McWA==WA3D).
- Structural hazard: McOpD & (McStartE | cnt>2). This holds the next multi-cycle op in D until it would issue at cnt<=1.
- McStall = RAW | WAW | structural.
- Control outputs:
  - PCWrPendingF = PCSrcD | PCSrcE | PCSrcM
  - StallF = LDRStall | McStall | PCWrPendingF
  - StallD = LDRStall | McStall
  - FlushD = PCWrPendingF | PCSrcW | BranchTakenE
  - FlushE = LDRStall | McStall | BranchTakenE
- ZERO_REG=1 masks every address-0 comparison and sb[0] write.

## Timing
- Reset values: sb=0, cnt=0, McWA=0, McWriteW=0, McBusy=0. Combinational outputs follow their inputs during reset.
- Reset mid-operation discards the pending write: McWriteW never asserts for it and the scoreboard is empty on the next cycle.
- Latency: issue at cycle t gives McWriteW in cycle t+MC_LAT. McBusy is high in cycles t+1..t+MC_LAT.
- Back-to-back: a new issue in the McWriteW cycle is legal. The old bit clears, the new bit sets, and the next McWriteW is at t+2*MC_LAT.
- Stall and forward outputs are valid in the same cycle as their inputs, with no registered delay.

## Test plan
- Forwarding, with RegWriteM=RegWriteW=1, RA1E=1, RA2E=2, WA3M=0, WA3W=2 -> FowardAE=00, FowardBE=01, match=4'b1000. Then set WA3M=2 -> FowardBE=10, match=4'b1100.
- Load-use: MemToRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1, FlushD=0. With RA2D=6 -> all 0.
- Multi-cycle RAW, MC_LAT=4: issue WA3E=7 at cycle 0, RA1D=7 held -> StallD=1 in cycles 0..3, McWriteW=1 and McWA=7 in cycle 4, StallD=0 in cycle 4 via bypass, sb[7]=0 in cycle 5.
- Structural: issue at cycle 0, McOpD=1 from cycle 1 -> StallD=1 in cycles 1..2, 0 in cycle 3. Issue at cycle 4 coincides with McWriteW and sets a new sb bit.
- Reset mid-op: issue WA3E=9, assert reset in cycle 2 -> cycle 3 shows cnt=0, sb[9]=0, McBusy=0, and McWriteW never pulses.
- ZERO_REG=1: RegWriteM=1, WA3M=0, RA1E=0 -> FowardAE=00, match=0. Issue WA3E=0, RA1D=0 -> no stall.

Source files
------------

// File: rtl/hazard_mc.sv
// Hazard unit for the five-stage pipeline: forwarding, load-use, branch flush,
// and a scoreboarded multi-cycle execution unit with a fixed-latency counter.
module hazard_mc #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned MC_LAT   = 4,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] RA1D,
  input  logic [ADDR_W-1:0] RA2D,
  input  logic [ADDR_W-1:0] WA3D,
  input  logic              RegWriteD,
  input  logic              McOpD,
  input  logic [ADDR_W-1:0] RA1E,
  input  logic [ADDR_W-1:0] RA2E,
  input  logic [ADDR_W-1:0] WA3E,
  input  logic              MemToRegE,
  input  logic              McStartE,
  input  logic              BranchTakenE,
  input  logic [ADDR_W-1:0] WA3M,
  input  logic [ADDR_W-1:0] WA3W,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              PCSrcD,
  input  logic              PCSrcE,
  input  logic              PCSrcM,
  input  logic              PCSrcW,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        FowardAE,
  output logic [1:0]        FowardBE,
  output logic [3:0]        match,
  output logic              McWriteW,
  output logic [ADDR_W-1:0] McWA,
  output logic              McBusy
);

  localparam int unsigned NREG  = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 4;

  logic [NREG-1:0]   sb_q, sb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mcwa_q, mcwa_d;

  logic issue;
  logic ldr_stall;
  logic raw1, raw2, waw, structural;
  logic mc_stall;
  logic pc_wr_pending_f;

  // Address 0 is optionally hard-wired and then never takes part in a hazard.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic addr_eq(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    return (a == b) && addr_ok(a);
  endfunction

  // A pending result written this cycle is visible to decode (write-first regfile).
  function automatic logic raw_hazard(input logic [ADDR_W-1:0] ra);
    logic issue_hit;
    logic bypass;
    issue_hit = McStartE && addr_eq(WA3E, ra);
    bypass    = McWriteW && addr_eq(mcwa_q, ra) && !issue_hit;
    return (sb_q[ra] && !bypass) || issue_hit;
  endfunction

  assign match[0] = RegWriteM && addr_eq(RA1E, WA3M);
  assign match[1] = RegWriteW && addr_eq(RA1E, WA3W);
  assign match[2] = RegWriteM && addr_eq(RA2E, WA3M);
  assign match[3] = RegWriteW && addr_eq(RA2E, WA3W);

  assign FowardAE = match[0] ? 2'b10 : (match[1] ? 2'b01 : 2'b00);
  assign FowardBE = match[2] ? 2'b10 : (match[3] ? 2'b01 : 2'b00);

  assign ldr_stall = MemToRegE && (addr_eq(RA1D, WA3E) || addr_eq(RA2D, WA3E));

  assign McWriteW = (cnt_q == CNT_W'(1));
  assign McBusy   = (cnt_q != '0);
  assign McWA     = mcwa_q;
  assign issue    = McStartE && (cnt_q <= CNT_W'(1));

  assign raw1       = raw_hazard(RA1D);
  assign raw2       = raw_hazard(RA2D);
  assign waw        = RegWriteD && sb_q[WA3D] && !(McWriteW && addr_eq(mcwa_q, WA3D));
  assign structural = McOpD && (McStartE || (cnt_q > CNT_W'(2)));
  assign mc_stall   = raw1 || raw2 || waw || structural;

  assign pc_wr_pending_f = PCSrcD || PCSrcE || PCSrcM;

  assign StallF = ldr_stall || mc_stall || pc_wr_pending_f;
  assign StallD = ldr_stall || mc_stall;
  assign FlushD = pc_wr_pending_f || PCSrcW || BranchTakenE;
  assign FlushE = ldr_stall || mc_stall || BranchTakenE;

  // Issue is applied after the writeback clear so a same-address reissue keeps its bit.
  always_comb begin
    sb_d   = sb_q;
    cnt_d  = cnt_q;
    mcwa_d = mcwa_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (McWriteW) begin
      sb_d[mcwa_q] = 1'b0;
    end
    if (issue) begin
      cnt_d  = CNT_W'(MC_LAT);
      mcwa_d = WA3E;
      if (addr_ok(WA3E)) begin
        sb_d[WA3E] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_q   <= '0;
      cnt_q  <= '0;
      mcwa_q <= '0;
    end else begin
      sb_q   <= sb_d;
      cnt_q  <= cnt_d;
      mcwa_q <= mcwa_d;
    end
  end

endmodule
